// File: rtl/motor_pkg.sv
// Shared definitions for the per-side motor bridge drivers: FSM encoding,
// direction polarity and the default timing parameters used by both sides.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_SLEW_DOWN = 2'd2,
    ST_DEAD      = 2'd3
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // 32768-clock PWM period, 1 ms dead time and 1/16-scale slew at 100 MHz
  localparam int PWM_BITS_DEF    = 15;
  localparam int DEAD_CYCLES_DEF = 100000;
  localparam int RAMP_STEP_DEF   = 2048;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter; wraps at all-ones and flags that last count
// with period_tick (combinational from the count register, no backpressure).
module pwm_period_counter
  import motor_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  output logic [PWM_BITS-1:0] cnt,
  output logic                period_tick
);

  logic [PWM_BITS-1:0] cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PWM_BITS'(1);
    end
  end

  assign cnt         = cnt_q;
  assign period_tick = (cnt_q == {PWM_BITS{1'b1}});

endmodule

// File: rtl/motor_side_driver.sv
// One H-bridge side: slew-limited duty updated only at period boundaries, ramp-down
// plus dead time on reversal; outputs registered (1 clock), cmd_en=0 coasts immediately.
module motor_side_driver
  import motor_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int RAMP_STEP   = RAMP_STEP_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                cmd_en,
  input  logic                cmd_dir,
  input  logic [PWM_BITS-1:0] cmd_duty,
  output logic                pwm_out,
  output logic                in_fwd,
  output logic                in_rev,
  output logic                period_tick,
  output logic                busy
);

  localparam int                DW        = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0]     DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [PWM_BITS:0] STEP      = (PWM_BITS + 1)'(RAMP_STEP);

  // One slew step toward tgt; the extra bit keeps the distance compare wrap-free
  function automatic logic [PWM_BITS-1:0] ramp(input logic [PWM_BITS-1:0] cur,
                                               input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS:0] c;
    logic [PWM_BITS:0] t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t >= c) begin
      ramp = (t - c <= STEP) ? tgt : cur + STEP[PWM_BITS-1:0];
    end else begin
      ramp = (c - t <= STEP) ? tgt : cur - STEP[PWM_BITS-1:0];
    end
  endfunction

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] cnt_next;
  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_q, dir_d;
  logic [DW-1:0]       dead_q, dead_d;
  logic                pwm_q, pwm_d;
  logic                fwd_q, fwd_d;
  logic                rev_q, rev_d;
  logic                drive_d;

  pwm_period_counter #(
    .PWM_BITS(PWM_BITS)
  ) u_cnt (
    .clock      (clock),
    .resetn     (resetn),
    .cnt        (cnt),
    .period_tick(period_tick)
  );

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    dir_d    = dir_q;
    dead_d   = dead_q;
    cnt_next = cnt + PWM_BITS'(1);
    if (!cmd_en) begin
      state_d = ST_IDLE;
      duty_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          if (period_tick) begin
            dir_d   = cmd_dir;
            state_d = ST_RUN;
            duty_d  = ramp('0, cmd_duty);
          end
        end
        ST_RUN: begin
          // A flip on a tick already ramps toward 0 in that same tick
          if (cmd_dir != dir_q) begin
            state_d = ST_SLEW_DOWN;
            if (period_tick) duty_d = ramp(duty_q, '0);
          end else if (period_tick) begin
            duty_d = ramp(duty_q, cmd_duty);
          end
        end
        ST_SLEW_DOWN: begin
          if (cmd_dir == dir_q) begin
            state_d = ST_RUN;
            if (period_tick) duty_d = ramp(duty_q, cmd_duty);
          end else if (period_tick) begin
            duty_d = ramp(duty_q, '0);
            if (duty_d == '0) begin
              state_d = ST_DEAD;
              dead_d  = DEAD_LOAD;
            end
          end
        end
        ST_DEAD: begin
          duty_d = '0;
          if (dead_q == '0) begin
            dir_d   = cmd_dir;
            state_d = ST_RUN;
          end else begin
            dead_d = dead_q - DW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Polarity is derived from the next state alone, so fwd and rev are exclusive
    drive_d = (state_d == ST_RUN) || (state_d == ST_SLEW_DOWN);
    pwm_d   = drive_d && (cnt_next < duty_d);
    fwd_d   = drive_d && (dir_d == DIR_FWD);
    rev_d   = drive_d && (dir_d == DIR_REV);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      dir_q   <= DIR_FWD;
      dead_q  <= '0;
      pwm_q   <= 1'b0;
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      pwm_q   <= pwm_d;
      fwd_q   <= fwd_d;
      rev_q   <= rev_d;
    end
  end

  assign pwm_out = pwm_q;
  assign in_fwd  = fwd_q;
  assign in_rev  = rev_q;
  assign busy    = (state_q == ST_SLEW_DOWN) || (state_q == ST_DEAD);

endmodule

// File: tb/tb_motor_side_driver.sv
// Bench for motor_side_driver at PWM_BITS=4, DEAD_CYCLES=8, RAMP_STEP=4.
module tb_motor_side_driver;

  localparam int PB   = 4;
  localparam int DC   = 8;
  localparam int RS   = 4;
  localparam int PMAX = 15;

  logic          clock = 1'b0;
  logic          resetn;
  logic          cmd_en;
  logic          cmd_dir;
  logic [PB-1:0] cmd_duty;
  logic          pwm_out, in_fwd, in_rev, period_tick, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_prints = 0;

  motor_side_driver #(
    .PWM_BITS   (PB),
    .DEAD_CYCLES(DC),
    .RAMP_STEP  (RS)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .cmd_en     (cmd_en),
    .cmd_dir    (cmd_dir),
    .cmd_duty   (cmd_duty),
    .pwm_out    (pwm_out),
    .in_fwd     (in_fwd),
    .in_rev     (in_rev),
    .period_tick(period_tick),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  localparam int M_OFF = 0, M_DRIVE = 1, M_BRAKE = 2, M_GAP = 3;
  int   m_cnt = 0, m_duty = 0, m_mode = M_OFF, m_gap = 0;
  logic m_dir = 1'b1;
  logic e_pwm = 1'b0, e_fwd = 1'b0, e_rev = 1'b0;

  function automatic int step_toward(input int cur, input int tgt);
    if (tgt - cur <= RS && cur - tgt <= RS) return tgt;
    return (tgt > cur) ? cur + RS : cur - RS;
  endfunction

  initial begin
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        m_cnt = 0; m_duty = 0; m_dir = 1'b1; m_mode = M_OFF; m_gap = 0;
      end else begin
        bit tick;
        tick = (m_cnt == PMAX);
        if (!cmd_en) begin
          m_mode = M_OFF; m_duty = 0;
        end else if (m_mode == M_OFF) begin
          if (tick) begin
            m_dir = cmd_dir; m_mode = M_DRIVE; m_duty = step_toward(0, int'(cmd_duty));
          end
        end else if (m_mode == M_DRIVE) begin
          if (cmd_dir != m_dir) begin
            m_mode = M_BRAKE;
            if (tick) m_duty = step_toward(m_duty, 0);
          end else if (tick) m_duty = step_toward(m_duty, int'(cmd_duty));
        end else if (m_mode == M_BRAKE) begin
          if (cmd_dir == m_dir) begin
            m_mode = M_DRIVE;
            if (tick) m_duty = step_toward(m_duty, int'(cmd_duty));
          end else if (tick) begin
            m_duty = step_toward(m_duty, 0);
            if (m_duty == 0) begin m_mode = M_GAP; m_gap = DC; end
          end
        end else begin
          m_gap = m_gap - 1;
          if (m_gap == 0) begin m_dir = cmd_dir; m_mode = M_DRIVE; end
        end
        m_cnt = tick ? 0 : m_cnt + 1;
      end
      e_pwm = (m_mode == M_DRIVE || m_mode == M_BRAKE) && (m_cnt < m_duty);
      e_fwd = (m_mode == M_DRIVE || m_mode == M_BRAKE) && m_dir;
      e_rev = (m_mode == M_DRIVE || m_mode == M_BRAKE) && !m_dir;
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      logic [4:0] got, want;
      @(negedge clock);
      got  = {pwm_out, in_fwd, in_rev, busy, period_tick};
      want = {e_pwm, e_fwd, e_rev, (m_mode == M_BRAKE || m_mode == M_GAP), (m_cnt == PMAX)};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        if (n_prints < 20) begin
          n_prints++;
          $display("FAIL model_cycle t=%0t pwm/fwd/rev/busy/tick got %b want %b", $time, got, want);
        end
      end
      n_tests++;
      if (in_fwd && in_rev) begin
        n_fail++;
        $display("FAIL shoot_through t=%0t fwd=%b rev=%b want not both 1", $time, in_fwd, in_rev);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic en;
    logic dir;
    int   duty;
    int   exp_cnt;
    logic exp_fwd;
    logic exp_rev;
    int   exp_dead;
  } row_t;
  row_t tbl[$];

  task automatic add(input logic en, input logic dir, input int duty, input int c,
                     input logic f, input logic r, input int d);
    row_t x;
    x = '{en, dir, duty, c, f, r, d};
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Called at the negedge of the last count; measures the following full period
  task automatic run_row(input int i);
    int hi, dz;
    cmd_en = tbl[i].en; cmd_dir = tbl[i].dir; cmd_duty = PB'(tbl[i].duty);
    hi = 0; dz = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      if (pwm_out) hi++;
      if (busy && !in_fwd && !in_rev) dz++;
    end
    chk($sformatf("row%0d_high_count", i), hi, tbl[i].exp_cnt);
    chk($sformatf("row%0d_polarity", i), {in_fwd, in_rev}, {tbl[i].exp_fwd, tbl[i].exp_rev});
    chk($sformatf("row%0d_dead_clocks", i), dz, tbl[i].exp_dead);
  endtask

  task automatic wait_tick(input string name, output int active);
    bit found;
    active = 0; found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (pwm_out || in_fwd || in_rev) active++;
      if (period_tick) found = 1;
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL %s: period_tick not seen within 40 clocks, want one", name);
    end
  endtask

  initial begin
    int act, k;
    resetn = 1'b0; cmd_en = 1'b0; cmd_dir = 1'b1; cmd_duty = '0;
    // ramp up fwd, one-period reversal, saturating ramps
    add(1,1,12, 4,1,0,0); add(1,1,12, 8,1,0,0); add(1,1,12,12,1,0,0); add(1,1,12,12,1,0,0);
    add(1,0,12, 8,1,0,0); add(1,1,12,12,1,0,0);
    add(1,1, 2, 8,1,0,0); add(1,1, 2, 4,1,0,0); add(1,1, 2, 2,1,0,0);
    add(1,1,15, 6,1,0,0); add(1,1,15,10,1,0,0); add(1,1,15,14,1,0,0); add(1,1,15,15,1,0,0);
    add(1,1,12,12,1,0,0);
    // full reversal with dead time
    add(1,0,12, 8,1,0,0); add(1,0,12, 4,1,0,0); add(1,0,12, 0,0,1,8);
    add(1,0,12, 4,0,1,0); add(1,0,12, 8,0,1,0); add(1,0,12,12,0,1,0);
    // restart after coast, then start of a reversal
    add(1,0,12, 4,0,1,0); add(1,0,12, 8,0,1,0);
    add(1,1,12, 4,0,1,0);

    #3 chk("reset_state", {pwm_out, in_fwd, in_rev, busy, period_tick}, 0);
    @(negedge clock); @(negedge clock); #2 resetn = 1'b1;
    wait_tick("align", act);
    chk("idle_outputs", act, 0);

    for (int i = 0; i <= 19; i++) run_row(i);

    // emergency coast mid-period
    repeat (5) @(negedge clock);
    cmd_en = 1'b0;
    @(negedge clock);
    chk("coast_outputs", {pwm_out, in_fwd, in_rev, busy}, 0);
    cmd_en = 1'b1;
    wait_tick("reenable", act);
    chk("reenable_hold_until_tick", act, 0);
    for (int i = 20; i <= 22; i++) run_row(i);

    // reset while in dead time
    repeat (3) @(negedge clock);
    chk("in_dead", {busy, in_fwd, in_rev}, 3'b100);
    #2 resetn = 1'b0;
    #1 chk("async_reset", {pwm_out, in_fwd, in_rev, busy, period_tick}, 0);
    @(negedge clock); #2 resetn = 1'b1;
    k = 0;
    for (int j = 1; j <= 40 && k == 0; j++) begin
      @(negedge clock);
      if (period_tick) k = j;
    end
    chk("cnt_restart_clocks", k, 15);
    chk("idle_after_reset", {busy, in_fwd, in_rev, pwm_out}, 0);

    // randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(negedge clock);
      r = $urandom_range(0, 999);
      if (r < 3) cmd_en = 1'b0;
      else if (r < 30) cmd_en = 1'b1;
      else if (r >= 100 && r < 108) cmd_dir = ~cmd_dir;
      else if (r >= 200 && r < 260) cmd_duty = PB'($urandom_range(0, 15));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
